// File: rtl/coll_engine_pkg.sv
// Shared definitions for the pong collision engine.
//   - Direction encodings for the ball motion inputs (ball_dir_h / ball_dir_v).
//   - Default table, ball and paddle geometry; coll_engine parameter defaults
//     take their values from here.
//   - FSM state type; the state is also exported on coll_engine.fsm_state.
package coll_engine_pkg;

  // Direction encodings.
  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;
  localparam logic DIR_UP    = 1'b0;
  localparam logic DIR_DOWN  = 1'b1;

  // Geometry defaults.
  localparam int DEF_W           = 11;
  localparam int DEF_SPW         = 4;
  localparam int DEF_TABLE_LEFT  = 16;
  localparam int DEF_TABLE_RIGHT = 624;
  localparam int DEF_TABLE_TOP   = 16;
  localparam int DEF_TABLE_BOT   = 464;
  localparam int DEF_BALL_HSIZE  = 8;
  localparam int DEF_BALL_VSIZE  = 8;
  localparam int DEF_PADDLE_W    = 8;
  localparam int DEF_PADDLE_H    = 64;

  // One evaluation per frame: IDLE -> SAMPLE -> VERT -> HORIZ -> DONE -> IDLE.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SAMPLE = 3'd1,
    ST_VERT   = 3'd2,
    ST_HORIZ  = 3'd3,
    ST_DONE   = 3'd4
  } coll_state_e;

endpackage

// File: rtl/coll_engine_vblank_sync.sv
// Two-flop synchroniser for an asynchronous level (vblank) with a rising-edge
// pulse.
//   clk   in  1  destination clock
//   rst_n in  1  async active-low reset, clears both flops
//   din   in  1  asynchronous level input
//   rise  out 1  one-clock pulse, sync1 & ~sync2
module coll_engine_vblank_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic rise
);

  logic sync1;
  logic sync2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= din;
      sync2 <= sync1;
    end
  end

  assign rise = sync1 & ~sync2;

endmodule

// File: rtl/coll_engine.sv
// 2-D collision engine for the pong table.
// Once per frame, on the rising edge of vblank, the ball's next position is
// checked against the top/bottom walls, both paddle faces and both goal lines.
// Results are registered and announced by a one-clock result_valid pulse
// four clocks after the synchronised rise (cycle E):
//   E+1 SAMPLE latch inputs, E+2 VERT wall check, E+3 HORIZ paddle/goal
//   check, E+4 DONE outputs valid.
// Ports:
//   clk, rst_n                 pixel clock, async active-low reset
//   vblank                     asynchronous vertical blank level
//   left/right_paddle_pos [W]  top row of each paddle
//   ball_dir_h / ball_dir_v    DIR_LEFT/DIR_RIGHT, DIR_UP/DIR_DOWN
//   ball_h, ball_v [W]         ball top-left corner
//   ball_speed_h/_v [SPW]      pixels per frame per axis
//   coll_paddle_l/_r           ball crosses the left/right paddle face
//   coll_wall_v                ball reaches the top or bottom wall
//   score_l / score_r          ball reaches the right / left goal line
//   hit_offset [W]             ball centre minus hit paddle top, [0,PADDLE_H-1]
//   result_valid               one-clock pulse, outputs above refreshed
//   fsm_state [3]              current FSM state (debug)
// Handshake: result_valid is a pure strobe with no ready; the consumer must
// sample the outputs in that cycle or later, as they hold until the next DONE.
module coll_engine
  import coll_engine_pkg::*;
#(
  parameter int W           = DEF_W,
  parameter int SPW         = DEF_SPW,
  parameter int TABLE_LEFT  = DEF_TABLE_LEFT,
  parameter int TABLE_RIGHT = DEF_TABLE_RIGHT,
  parameter int TABLE_TOP   = DEF_TABLE_TOP,
  parameter int TABLE_BOT   = DEF_TABLE_BOT,
  parameter int BALL_HSIZE  = DEF_BALL_HSIZE,
  parameter int BALL_VSIZE  = DEF_BALL_VSIZE,
  parameter int PADDLE_W    = DEF_PADDLE_W,
  parameter int PADDLE_H    = DEF_PADDLE_H
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           vblank,
  input  logic [W-1:0]   left_paddle_pos,
  input  logic [W-1:0]   right_paddle_pos,
  input  logic           ball_dir_h,
  input  logic           ball_dir_v,
  input  logic [W-1:0]   ball_h,
  input  logic [W-1:0]   ball_v,
  input  logic [SPW-1:0] ball_speed_h,
  input  logic [SPW-1:0] ball_speed_v,
  output logic           coll_paddle_l,
  output logic           coll_paddle_r,
  output logic           coll_wall_v,
  output logic           score_l,
  output logic           score_r,
  output logic [W-1:0]   hit_offset,
  output logic           result_valid,
  output logic [2:0]     fsm_state
);

  // All geometry arithmetic is one bit wider than the coordinates so that
  // additions never truncate.
  typedef logic [W:0] cw_t;

  localparam cw_t C_TOP        = cw_t'(TABLE_TOP);
  localparam cw_t C_BOT        = cw_t'(TABLE_BOT);
  localparam cw_t C_LEFT       = cw_t'(TABLE_LEFT);
  localparam cw_t C_RIGHT      = cw_t'(TABLE_RIGHT);
  localparam cw_t C_LEFT_FACE  = cw_t'(TABLE_LEFT + PADDLE_W);
  localparam cw_t C_RIGHT_FACE = cw_t'(TABLE_RIGHT - PADDLE_W);
  localparam cw_t C_BH         = cw_t'(BALL_HSIZE);
  localparam cw_t C_BV         = cw_t'(BALL_VSIZE);
  localparam cw_t C_BV_HALF    = cw_t'(BALL_VSIZE / 2);
  localparam cw_t C_PH         = cw_t'(PADDLE_H);
  localparam cw_t C_PH_MAX     = cw_t'(PADDLE_H - 1);

  // Subtraction whose borrow saturates at zero instead of wrapping.
  function automatic cw_t sat_sub(input cw_t a, input cw_t b);
    return (a >= b) ? (a - b) : '0;
  endfunction

  // --------------------------------------------------------------------------
  // vblank synchroniser
  // --------------------------------------------------------------------------
  logic rise;

  coll_engine_vblank_sync u_vblank_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (vblank),
    .rise  (rise)
  );

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------
  coll_state_e state_q;
  coll_state_e state_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // A rise seen in any state other than IDLE is dropped, so a glitchy or
  // early vblank cannot start a second evaluation mid-frame.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (rise) state_d = ST_SAMPLE;
      ST_SAMPLE: state_d = ST_VERT;
      ST_VERT:   state_d = ST_HORIZ;
      ST_HORIZ:  state_d = ST_DONE;
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  assign fsm_state = state_q;

  // --------------------------------------------------------------------------
  // Input snapshot (taken in SAMPLE so later stages see a stable frame)
  // --------------------------------------------------------------------------
  logic           dir_h_q;
  logic           dir_v_q;
  logic [W-1:0]   ball_h_q;
  logic [W-1:0]   ball_v_q;
  logic [SPW-1:0] spd_h_q;
  logic [SPW-1:0] spd_v_q;
  logic [W-1:0]   lp_q;
  logic [W-1:0]   rp_q;
  logic           wall_q;

  // --------------------------------------------------------------------------
  // Geometry
  // --------------------------------------------------------------------------
  cw_t  bh;
  cw_t  bv;
  cw_t  sh;
  cw_t  sv;
  cw_t  lp;
  cw_t  rp;
  cw_t  nv;
  cw_t  nh;
  cw_t  pad_top;
  cw_t  off_raw;
  cw_t  off_c;
  logic wall_c;
  logic ovl_l;
  logic ovl_r;
  logic hit_l_c;
  logic hit_r_c;
  logic score_l_c;
  logic score_r_c;

  always_comb begin
    bh = {1'b0, ball_h_q};
    bv = {1'b0, ball_v_q};
    sh = cw_t'(spd_h_q);
    sv = cw_t'(spd_v_q);
    lp = {1'b0, lp_q};
    rp = {1'b0, rp_q};

    // Vertical: next row against the wall the ball is heading for.
    nv     = (dir_v_q == DIR_UP) ? sat_sub(bv, sv) : (bv + sv);
    wall_c = (dir_v_q == DIR_UP) ? (nv <= C_TOP) : ((nv + C_BV) >= C_BOT);

    // Horizontal: next column; overlap uses the current row.
    nh    = (dir_h_q == DIR_LEFT) ? sat_sub(bh, sh) : (bh + sh);
    ovl_l = ((bv + C_BV) > lp) && (bv < (lp + C_PH));
    ovl_r = ((bv + C_BV) > rp) && (bv < (rp + C_PH));

    // A paddle hit needs the ball to start on the table side of the face, so
    // a ball already behind the paddle falls through to the goal line.
    hit_l_c   = (dir_h_q == DIR_LEFT) && (nh <= C_LEFT_FACE) && ovl_l &&
                (bh >= C_LEFT_FACE);
    hit_r_c   = (dir_h_q == DIR_RIGHT) && ((nh + C_BH) >= C_RIGHT_FACE) &&
                ovl_r && ((bh + C_BH) <= C_RIGHT_FACE);
    score_r_c = (dir_h_q == DIR_LEFT) && (nh <= C_LEFT) && !hit_l_c;
    score_l_c = (dir_h_q == DIR_RIGHT) && ((nh + C_BH) >= C_RIGHT) && !hit_r_c;

    // Offset of the ball centre below the hit paddle's top row, clamped.
    pad_top = hit_l_c ? lp : rp;
    off_raw = sat_sub(bv + C_BV_HALF, pad_top);
    off_c   = '0;
    if (hit_l_c || hit_r_c) off_c = (off_raw > C_PH_MAX) ? C_PH_MAX : off_raw;
  end

  // off_c never exceeds PADDLE_H-1, so its extra top bit is always zero.
  logic unused_off_msb;
  assign unused_off_msb = off_c[W];

  // --------------------------------------------------------------------------
  // Pipeline and output registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dir_h_q       <= 1'b0;
      dir_v_q       <= 1'b0;
      ball_h_q      <= '0;
      ball_v_q      <= '0;
      spd_h_q       <= '0;
      spd_v_q       <= '0;
      lp_q          <= '0;
      rp_q          <= '0;
      wall_q        <= 1'b0;
      coll_paddle_l <= 1'b0;
      coll_paddle_r <= 1'b0;
      coll_wall_v   <= 1'b0;
      score_l       <= 1'b0;
      score_r       <= 1'b0;
      hit_offset    <= '0;
      result_valid  <= 1'b0;
    end else begin
      result_valid <= (state_q == ST_HORIZ);

      if (state_q == ST_SAMPLE) begin
        dir_h_q  <= ball_dir_h;
        dir_v_q  <= ball_dir_v;
        ball_h_q <= ball_h;
        ball_v_q <= ball_v;
        spd_h_q  <= ball_speed_h;
        spd_v_q  <= ball_speed_v;
        lp_q     <= left_paddle_pos;
        rp_q     <= right_paddle_pos;
      end

      if (state_q == ST_VERT) wall_q <= wall_c;

      // All results update together on entry to DONE.
      if (state_q == ST_HORIZ) begin
        coll_wall_v   <= wall_q;
        coll_paddle_l <= hit_l_c;
        coll_paddle_r <= hit_r_c;
        score_l       <= score_l_c;
        score_r       <= score_r_c;
        hit_offset    <= off_c[W-1:0];
      end
    end
  end

endmodule

// File: tb/tb_coll_engine.sv
// Directed bench for coll_engine: a table of frames with hand-computed results,
// plus sequences for reset during an evaluation and a vblank re-rise while busy.
module tb_coll_engine;
  import coll_engine_pkg::*;

  localparam int W   = 11;
  localparam int SPW = 4;

  // ---------------------------------------------------------------- clock/reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic           vblank = 1'b0;
  logic [W-1:0]   left_paddle_pos = '0;
  logic [W-1:0]   right_paddle_pos = '0;
  logic           ball_dir_h = 1'b0;
  logic           ball_dir_v = 1'b0;
  logic [W-1:0]   ball_h = '0;
  logic [W-1:0]   ball_v = '0;
  logic [SPW-1:0] ball_speed_h = '0;
  logic [SPW-1:0] ball_speed_v = '0;
  logic           coll_paddle_l;
  logic           coll_paddle_r;
  logic           coll_wall_v;
  logic           score_l;
  logic           score_r;
  logic [W-1:0]   hit_offset;
  logic           result_valid;
  logic [2:0]     fsm_state;

  coll_engine dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .vblank           (vblank),
    .left_paddle_pos  (left_paddle_pos),
    .right_paddle_pos (right_paddle_pos),
    .ball_dir_h       (ball_dir_h),
    .ball_dir_v       (ball_dir_v),
    .ball_h           (ball_h),
    .ball_v           (ball_v),
    .ball_speed_h     (ball_speed_h),
    .ball_speed_v     (ball_speed_v),
    .coll_paddle_l    (coll_paddle_l),
    .coll_paddle_r    (coll_paddle_r),
    .coll_wall_v      (coll_wall_v),
    .score_l          (score_l),
    .score_r          (score_r),
    .hit_offset       (hit_offset),
    .result_valid     (result_valid),
    .fsm_state        (fsm_state)
  );

  // ---------------------------------------------------------------- vectors
  typedef struct {
    logic           dh;
    logic           dv;
    logic [W-1:0]   bh;
    logic [W-1:0]   bv;
    logic [SPW-1:0] sh;
    logic [SPW-1:0] sv;
    logic [W-1:0]   lp;
    logic [W-1:0]   rp;
    logic           e_pl;
    logic           e_pr;
    logic           e_wall;
    logic           e_sl;
    logic           e_sr;
    logic [W-1:0]   e_off;
  } vec_t;

  vec_t vecs[$];

  int n_vec  = 0;
  int n_fail = 0;

  function automatic vec_t mk(input logic dh, input logic dv,
                              input int bh, input int bv, input int sh, input int sv,
                              input int lp, input int rp,
                              input logic pl, input logic pr, input logic wall,
                              input logic sl, input logic sr, input int off);
    vec_t v;
    v.dh = dh; v.dv = dv;
    v.bh = W'(bh); v.bv = W'(bv); v.sh = SPW'(sh); v.sv = SPW'(sv);
    v.lp = W'(lp); v.rp = W'(rp);
    v.e_pl = pl; v.e_pr = pr; v.e_wall = wall; v.e_sl = sl; v.e_sr = sr;
    v.e_off = W'(off);
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // ---------------------------------------------------------------- drivers
  task automatic drive_inputs(input vec_t v);
    ball_dir_h       = v.dh;
    ball_dir_v       = v.dv;
    ball_h           = v.bh;
    ball_v           = v.bv;
    ball_speed_h     = v.sh;
    ball_speed_v     = v.sv;
    left_paddle_pos  = v.lp;
    right_paddle_pos = v.rp;
  endtask

  task automatic check_results(input string tag, input vec_t v);
    check({tag, ".coll_paddle_l"}, 32'(coll_paddle_l), 32'(v.e_pl));
    check({tag, ".coll_paddle_r"}, 32'(coll_paddle_r), 32'(v.e_pr));
    check({tag, ".coll_wall_v"},   32'(coll_wall_v),   32'(v.e_wall));
    check({tag, ".score_l"},       32'(score_l),       32'(v.e_sl));
    check({tag, ".score_r"},       32'(score_r),       32'(v.e_sr));
    check({tag, ".hit_offset"},    32'(hit_offset),    32'(v.e_off));
  endtask

  // Raise vblank, wait (bounded) for result_valid, check latency and results.
  // Five clock edges after vblank rises: two for the synchroniser/rise, then
  // SAMPLE, VERT, HORIZ, and result_valid is high in DONE.
  task automatic run_frame(input string tag, input vec_t v);
    int lat;
    bit seen;
    @(negedge clk);
    drive_inputs(v);
    vblank = 1'b1;
    lat = 0;
    seen = 1'b0;
    while (!seen && lat < 20) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (result_valid) seen = 1'b1;
    end
    check({tag, ".latency"}, 32'(lat), 32'd5);
    if (seen) begin
      check({tag, ".state_done"}, 32'(fsm_state), 32'(ST_DONE));
      check_results(tag, v);
      @(negedge clk);
      check({tag, ".valid_pulse"}, 32'(result_valid), 32'd0);
    end
    vblank = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  // ---------------------------------------------------------------- watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "bench timeout");
  end

  // ---------------------------------------------------------------- test
  initial begin
    int pulses;
    //            dh         dv        bh   bv  sh sv  lp   rp   pl pr wl sl sr off
    vecs.push_back(mk(DIR_RIGHT, DIR_UP,   300,  20, 1, 4, 200, 200, 0, 0, 1, 0, 0, 0));  // 0 top wall
    vecs.push_back(mk(DIR_RIGHT, DIR_UP,   300,  21, 1, 4, 200, 200, 0, 0, 0, 0, 0, 0));  // 1 just clear
    vecs.push_back(mk(DIR_LEFT,  DIR_DOWN,  27, 100, 4, 0,  80, 300, 1, 0, 0, 0, 0, 24)); // 2 left paddle
    vecs.push_back(mk(DIR_LEFT,  DIR_DOWN,  27, 100, 4, 0, 200, 300, 0, 0, 0, 0, 0, 0));  // 3 left miss
    vecs.push_back(mk(DIR_LEFT,  DIR_DOWN,  19, 100, 4, 0, 200, 300, 0, 0, 0, 0, 1, 0));  // 4 right scores
    vecs.push_back(mk(DIR_RIGHT, DIR_DOWN, 605, 460, 4, 2,   0, 420, 0, 1, 1, 0, 0, 44)); // 5 corner right
    vecs.push_back(mk(DIR_LEFT,  DIR_DOWN,   2, 100,15, 0, 300, 300, 0, 0, 0, 0, 1, 0));  // 6 borrow sat
    vecs.push_back(mk(DIR_LEFT,  DIR_DOWN,  27, 200, 4, 0, 140, 300, 1, 0, 0, 0, 0, 63)); // 7 clamp high
    vecs.push_back(mk(DIR_LEFT,  DIR_DOWN,  27,  75, 4, 0,  80, 300, 1, 0, 0, 0, 0, 0));  // 8 clamp low
    vecs.push_back(mk(DIR_RIGHT, DIR_DOWN, 620, 100, 4, 0, 300, 300, 0, 0, 0, 1, 0, 0));  // 9 left scores
    vecs.push_back(mk(DIR_RIGHT, DIR_DOWN, 300, 454, 1, 2, 200, 200, 0, 0, 1, 0, 0, 0));  // 10 bottom wall
    vecs.push_back(mk(DIR_RIGHT, DIR_DOWN, 300, 453, 1, 2, 200, 200, 0, 0, 0, 0, 0, 0));  // 11 just clear
    vecs.push_back(mk(DIR_LEFT,  DIR_UP,    16, 300, 0, 0,   0, 200, 0, 0, 0, 0, 1, 0));  // 12 speed 0 goal
    vecs.push_back(mk(DIR_LEFT,  DIR_UP,    27,  18, 4, 3,   0, 200, 1, 0, 1, 0, 0, 22)); // 13 corner left
    vecs.push_back(mk(DIR_RIGHT, DIR_DOWN, 608, 100, 0, 0, 200,  80, 0, 1, 0, 0, 0, 24)); // 14 face exact
    vecs.push_back(mk(DIR_RIGHT, DIR_DOWN, 605, 100, 4, 0, 200, 300, 0, 0, 0, 0, 0, 0));  // 15 right miss

    // Reset state.
    repeat (3) @(negedge clk);
    check("reset.result_valid", 32'(result_valid), 32'd0);
    check("reset.state",        32'(fsm_state),    32'(ST_IDLE));
    check_results("reset", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Table-driven frames.
    foreach (vecs[i]) run_frame($sformatf("v%0d", i), vecs[i]);

    // Second vblank rise while the engine is busy must not start a new frame.
    @(negedge clk);
    drive_inputs(vecs[6]);
    vblank = 1'b1;
    pulses = 0;
    for (int c = 0; c < 25; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (c == 1) vblank = 1'b0;
      if (c == 2) vblank = 1'b1;
      if (c == 8) vblank = 1'b0;
      if (c == 5) check("busy_rise.back_to_idle", 32'(fsm_state), 32'(ST_IDLE));
      if (result_valid) begin
        pulses++;
        check("busy_rise.pulse_cycle", 32'(c), 32'd4);
        check("busy_rise.score_r",     32'(score_r), 32'd1);
      end
    end
    check("busy_rise.pulses", 32'(pulses), 32'd1);
    repeat (3) @(negedge clk);

    // Reset during HORIZ: outputs cleared, no result for that frame.
    run_frame("pre_reset", vecs[5]);
    @(negedge clk);
    drive_inputs(vecs[2]);
    vblank = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("mid_reset.in_horiz", 32'(fsm_state), 32'(ST_HORIZ));
    rst_n = 1'b0;
    @(negedge clk);
    vblank = 1'b0;
    check("mid_reset.state", 32'(fsm_state), 32'(ST_IDLE));
    check_results("mid_reset", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    for (int c = 0; c < 4; c++) begin
      check($sformatf("mid_reset.valid%0d", c), 32'(result_valid), 32'd0);
      @(negedge clk);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("post_reset.idle", 32'(fsm_state), 32'(ST_IDLE));
    check("post_reset.valid", 32'(result_valid), 32'd0);
    run_frame("post_reset", vecs[2]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
